// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - opcodes, state encoding and datapath select constants for multicycle_control
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [3:0] ST_FETCH  = 4'd0;
  localparam logic [3:0] ST_DECODE = 4'd1;
  localparam logic [3:0] ST_MEMADR = 4'd2;
  localparam logic [3:0] ST_MEMRD  = 4'd3;
  localparam logic [3:0] ST_MEMWB  = 4'd4;
  localparam logic [3:0] ST_MEMWR  = 4'd5;
  localparam logic [3:0] ST_EXEC   = 4'd6;
  localparam logic [3:0] ST_RWB    = 4'd7;
  localparam logic [3:0] ST_BEQ    = 4'd8;
  localparam logic [3:0] ST_ADDIEX = 4'd9;
  localparam logic [3:0] ST_ADDIWB = 4'd10;
  localparam logic [3:0] ST_JMP    = 4'd11;

  typedef enum logic [3:0] {
    S_FETCH  = ST_FETCH,
    S_DECODE = ST_DECODE,
    S_MEMADR = ST_MEMADR,
    S_MEMRD  = ST_MEMRD,
    S_MEMWB  = ST_MEMWB,
    S_MEMWR  = ST_MEMWR,
    S_EXEC   = ST_EXEC,
    S_RWB    = ST_RWB,
`ifdef MIPS_CTRL_ADDI_J_EN
    S_BEQ    = ST_BEQ,
    S_ADDIEX = ST_ADDIEX,
    S_ADDIWB = ST_ADDIWB,
    S_JMP    = ST_JMP
`else
    S_BEQ    = ST_BEQ
`endif
  } state_t;

  // Successor of DECODE; S_FETCH marks an unsupported (or unknown) opcode.
  function automatic state_t decode_next(input logic [5:0] op);
    state_t nxt;
    case (op)
      OP_RTYPE:     nxt = S_EXEC;
      OP_LW, OP_SW: nxt = S_MEMADR;
      OP_BEQ:       nxt = S_BEQ;
`ifdef MIPS_CTRL_ADDI_J_EN
      OP_ADDI:      nxt = S_ADDIEX;
      OP_J:         nxt = S_JMP;
`endif
      default:      nxt = S_FETCH;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - controller/datapath signal bundle; master = controller side
interface multicycle_control_if #(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 2,
  parameter int CNT_W    = 32
) ();

  logic [OPCODE_W-1:0] opcode;
  logic                zero;
  logic                mem_ready;
  logic                PCWrite;
  logic                PCWriteCond;
  logic                IorD;
  logic                MemRead;
  logic                MemWrite;
  logic                IRWrite;
  logic                MemToReg;
  logic                RegDst;
  logic                RegWrite;
  logic                ALUSrcA;
  logic [1:0]          ALUSrcB;
  logic [ALUOP_W-1:0]  ALUOp;
  logic [1:0]          PCSrc;
  logic                illegal_op;
  logic [3:0]          state;
  logic [CNT_W-1:0]    instr_cnt;

  modport master (
    input  opcode, zero, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc, illegal_op,
           state, instr_cnt
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc, illegal_op,
           state, instr_cnt
  );

endinterface

// File: rtl/mc_ctrl_outdec.sv
// rtl/mc_ctrl_outdec.sv - state to datapath control vector decoder (MIPS_CTRL_ADDI_J_EN adds addi/j rows)
module mc_ctrl_outdec
  import mips_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 2
) (
  input  state_t             i_state,
  input  logic               i_mem_ready,
  output logic               o_pc_write,
  output logic               o_pc_write_cond,
  output logic               o_iord,
  output logic               o_mem_read,
  output logic               o_mem_write,
  output logic               o_ir_write,
  output logic               o_mem_to_reg,
  output logic               o_reg_dst,
  output logic               o_reg_write,
  output logic               o_alu_src_a,
  output logic [1:0]         o_alu_src_b,
  output logic [ALUOP_W-1:0] o_alu_op,
  output logic [1:0]         o_pc_src
);

  always_comb begin
    o_pc_write      = 1'b0;
    o_pc_write_cond = 1'b0;
    o_iord          = 1'b0;
    o_mem_read      = 1'b0;
    o_mem_write     = 1'b0;
    o_ir_write      = 1'b0;
    o_mem_to_reg    = 1'b0;
    o_reg_dst       = 1'b0;
    o_reg_write     = 1'b0;
    o_alu_src_a     = 1'b0;
    o_alu_src_b     = SRCB_B;
    o_alu_op        = ALUOP_W'(ALU_ADD);
    o_pc_src        = PCSRC_ALU;
    case (i_state)
      S_FETCH: begin
        // IR and PC only advance on the cycle the instruction word arrives.
        o_mem_read  = 1'b1;
        o_alu_src_b = SRCB_FOUR;
        o_ir_write  = i_mem_ready;
        o_pc_write  = i_mem_ready;
      end
      S_DECODE: o_alu_src_b = SRCB_IMM_SL2;
      S_MEMADR: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        o_mem_read = 1'b1;
        o_iord     = 1'b1;
      end
      S_MEMWB: begin
        o_reg_write  = 1'b1;
        o_mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        o_mem_write = 1'b1;
        o_iord      = 1'b1;
      end
      S_EXEC: begin
        o_alu_src_a = 1'b1;
        o_alu_op    = ALUOP_W'(ALU_FUNCT);
      end
      S_RWB: begin
        o_reg_write = 1'b1;
        o_reg_dst   = 1'b1;
      end
      S_BEQ: begin
        o_alu_src_a     = 1'b1;
        o_alu_op        = ALUOP_W'(ALU_SUB);
        o_pc_write_cond = 1'b1;
        o_pc_src        = PCSRC_ALUOUT;
      end
`ifdef MIPS_CTRL_ADDI_J_EN
      S_ADDIEX: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = SRCB_IMM;
      end
      S_ADDIWB: o_reg_write = 1'b1;
      S_JMP: begin
        o_pc_write = 1'b1;
        o_pc_src   = PCSRC_JUMP;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS control FSM with retire counter; MIPS_CTRL_ADDI_J_EN enables addi/j
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 2,
  parameter int CNT_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_control_if.master bus
);

  state_t             r_state;
  logic [CNT_W-1:0]   r_instr_cnt;
  logic [OPCODE_W-1:0] w_opcode;
  state_t             w_decode_next;
  logic               w_retire;

  assign w_opcode      = bus.opcode;
  assign w_decode_next = decode_next(w_opcode);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:  if (bus.mem_ready) r_state <= S_DECODE;
        S_DECODE: r_state <= w_decode_next;
        S_MEMADR: r_state <= (w_opcode == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:  if (bus.mem_ready) r_state <= S_MEMWB;
        S_MEMWR:  if (bus.mem_ready) r_state <= S_FETCH;
        S_EXEC:   r_state <= S_RWB;
`ifdef MIPS_CTRL_ADDI_J_EN
        S_ADDIEX: r_state <= S_ADDIWB;
`endif
        default:  r_state <= S_FETCH;
      endcase
    end
  end

  // An instruction retires in its last state; a stalled store retires on its ready cycle.
  always_comb begin
    w_retire = 1'b0;
    case (r_state)
      S_MEMWB, S_RWB, S_BEQ: w_retire = 1'b1;
      S_MEMWR:               w_retire = bus.mem_ready;
`ifdef MIPS_CTRL_ADDI_J_EN
      S_ADDIWB, S_JMP:       w_retire = 1'b1;
`endif
      default:               w_retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr_cnt <= '0;
    end else if (w_retire) begin
      r_instr_cnt <= r_instr_cnt + 1'b1;
    end
  end

  assign bus.state      = r_state;
  assign bus.instr_cnt  = r_instr_cnt;
  assign bus.illegal_op = (r_state == S_DECODE) && (w_decode_next == S_FETCH);

  mc_ctrl_outdec #(
    .ALUOP_W(ALUOP_W)
  ) u_outdec (
    .i_state        (r_state),
    .i_mem_ready    (bus.mem_ready),
    .o_pc_write     (bus.PCWrite),
    .o_pc_write_cond(bus.PCWriteCond),
    .o_iord         (bus.IorD),
    .o_mem_read     (bus.MemRead),
    .o_mem_write    (bus.MemWrite),
    .o_ir_write     (bus.IRWrite),
    .o_mem_to_reg   (bus.MemToReg),
    .o_reg_dst      (bus.RegDst),
    .o_reg_write    (bus.RegWrite),
    .o_alu_src_a    (bus.ALUSrcA),
    .o_alu_src_b    (bus.ALUSrcB),
    .o_alu_op       (bus.ALUOp),
    .o_pc_src       (bus.PCSrc)
  );

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Main control unit for the multicycle MIPS datapath. It is the successor to the single-cycle opcode decoder. A registered FSM sequences each instruction through fetch, decode, execute, memory and writeback, and drives the datapath control signals per state. It adds a memory ready handshake, flags illegal opcodes in hardware and keeps a retired-instruction counter. It sits between the instruction register opcode field and the datapath muxes and enables.

Parameters:
OPCODE_W, 6, opcode field width
ALUOP_W, 2, ALU control class width (00 add, 01 sub, 10 funct-decoded)
CNT_W, 32, retired-instruction counter width

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
opcode  in  OPCODE_W  IR[31:26], valid from DECODE onward
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes access this cycle; tie high for fixed-latency memory
PCWrite  out  1  unconditional PC write
PCWriteCond  out  1  PC write if zero (beq)
IorD  out  1  memory address select (0 = PC, 1 = ALUOut)
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IRWrite  out  1  instruction register load
MemToReg  out  1  writeback select (1 = MDR)
RegDst  out  1  destination select (1 = rd)
RegWrite  out  1  register file write
ALUSrcA  out  1  0 = PC, 1 = A
ALUSrcB  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
ALUOp  out  ALUOP_W  ALU control class
PCSrc  out  2  00 ALU, 01 ALUOut, 10 jump target
illegal_op  out  1  one-cycle pulse when an unsupported opcode is decoded
state  out  4  current state encoding, for debug
instr_cnt  out  CNT_W  retired-instruction count

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, RWB, BEQ, ADDIEX, ADDIWB, JMP.
- Encoding is fixed in the package.
- State is a register. All outputs are decoded from state, except the three qualified outputs below. Any output not asserted in a state is 0.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00. IRWrite and PCWrite = mem_ready. Stay in FETCH until mem_ready=1, then go to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target precompute). Next state by opcode:
  - 000000 → EXEC
  - 100011 or 101011 → MEMADR
  - 000100 → BEQ
  - 001000 → ADDIEX (feature only)
  - 000010 → JMP (feature only)
  - any other opcode → FETCH, with illegal_op=1 for this cycle.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead=1, IorD=1. Hold until mem_ready, then go to MEMWB.
- MEMWB: RegWrite=1, MemToReg=1, RegDst=0. Go to FETCH.
- MEMWR: MemWrite=1, IorD=1. Hold until mem_ready, then go to FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Go to RWB.
- RWB: RegWrite=1, RegDst=1, MemToReg=0. Go to FETCH.
- BEQ: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSrc=01. Go to FETCH.
- Latency with mem_ready held at 1: beq 3 cycles, R-type 4, sw 4, lw 5 (counted from FETCH entry to FETCH re-entry).
- Each extra cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- instr_cnt increments by 1 on the final state of each legal instruction (MEMWB, RWB, BEQ, MEMWR with mem_ready=1, ADDIWB, JMP).
- instr_cnt wraps modulo 2^CNT_W. Illegal opcodes do not count.
- Reset: asynchronous. State goes to FETCH and instr_cnt to 0, so outputs show the FETCH vector immediately. IRWrite and PCWrite stay 0 while mem_ready=0.
- Reset asserted mid-instruction discards that instruction; no partial write is completed.
- opcode is sampled only in DECODE and MEMADR. Changes in other states are ignored.
- X or Z on opcode is decoded as illegal.

Optional Feature:
- Macro MIPS_CTRL_ADDI_J_EN.
- When defined, addi (001000) and j (000010) are supported:
  - ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to ADDIWB.
  - ADDIWB: RegWrite=1, RegDst=0, MemToReg=0. Go to FETCH.
  - JMP: PCWrite=1, PCSrc=10. Go to FETCH.
- When undefined, these three states are not compiled, and both opcodes take the illegal path (illegal_op pulse, return to FETCH).

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J)
  - the state encoding localparams
  - ALUOp constants (ALU_ADD, ALU_SUB, ALU_FUNCT)
  - ALUSrcB and PCSrc select constants.
- One sub-module, mc_ctrl_outdec, is natural: a combinational state → control vector decoder. The FSM and counter stay in multicycle_control.

Test Plan:
- Reset: rst_n=0 mid-EXEC, mem_ready=1 → state=FETCH and instr_cnt=0 asynchronously; MemRead=1, IRWrite=1, RegWrite=0.
- lw (opcode 100011), mem_ready=1 → states FETCH, DECODE, MEMADR, MEMRD, MEMWB. RegWrite=1 and MemToReg=1 only in cycle 5; instr_cnt 0→1.
- sw (opcode 101011), mem_ready low for 3 cycles in MEMWR → MemWrite=1 for 4 cycles; instr_cnt increments only in the mem_ready=1 cycle.
- beq (opcode 000100) with zero=1, then with zero=0 → PCWriteCond=1, PCSrc=01, ALUOp=01 in the third cycle both times; 3-cycle latency each.
- Illegal opcode 111111 → exactly one illegal_op pulse in DECODE, next state FETCH, instr_cnt unchanged.
- Opcode 001000 without the macro → illegal_op pulse. With MIPS_CTRL_ADDI_J_EN → ADDIEX then ADDIWB with RegWrite=1, RegDst=0. Separately, opcode 000010 → JMP with PCWrite=1, PCSrc=10.
